mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write) of the multi-cycle NPC core.
- Runs one outstanding transaction at a time, latches the request fields, and routes the response back to the owning requester.
- A per-transaction response timeout returns an error instead of hanging the core.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wmask width is DATA_W/8.
- TIMEOUT, 255, max cycles in WAIT before an error response; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  one-cycle IFU response pulse
- ifu_resp_err  out  1  IFU response is a timeout error
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  store byte mask
- lsu_resp_valid  out  1  one-cycle LSU response pulse
- lsu_resp_err  out  1  LSU response is a timeout error
- lsu_rdata  out  DATA_W  LSU read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  latched address
- mem_wen  out  1  latched write enable (0 for IFU)
- mem_wdata  out  DATA_W  latched write data (0 for IFU)
- mem_wmask  out  DATA_W/8  latched mask (0 for IFU)
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset is asynchronous, active-high. It sets state IDLE, owner IFU, last_grant IFU, timer 0, all latched mem_* fields 0.
- While rst is high, every output is 0.
- Reset mid-transaction abandons the transaction. No response is generated.
- States:
  - IDLE: if lsu_req_valid, grant LSU; else if ifu_req_valid, grant IFU.
    - Only the granted requester's ready is 1, combinationally, in IDLE only.
    - On valid&ready: latch addr/wen/wdata/wmask (IFU forces wen=0, wdata=0, wmask=0), record owner and last_grant, go to REQ.
  - REQ: mem_req_valid=1 with the latched fields, held stable until mem_req_ready. On mem_req_ready, go to WAIT and clear the timer.
  - WAIT: mem_req_valid=0.
    - On mem_resp_valid: pulse owner's resp_valid for that same cycle with rdata=mem_rdata and err=0; go to IDLE.
    - Else the timer increments. When timer==TIMEOUT-1 (TIMEOUT≠0): pulse owner's resp_valid with err=1, rdata=0; go to IDLE.
    - If mem_resp_valid arrives in the timeout cycle, the real response wins (err=0).
- Non-owner resp_valid/err/rdata are 0 at all times.
- mem_resp_valid seen in IDLE or REQ (late or stray) is dropped silently.
- Both ready outputs are 0 outside IDLE. Requesters hold valid and fields until ready.
- Minimum transaction: accept (IDLE) → REQ → response in WAIT → IDLE, i.e. 3 cycles, with the next accept on the 4th.
- Timer width is clog2(TIMEOUT+1) and it saturates, so there is no wrap.
- Loads and stores both wait for mem_resp_valid; a store response carries no meaningful rdata.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin. When both requesters are valid in IDLE, grant the one that is not last_grant. With a single requester valid, grant it.
- Undefined: fixed priority, LSU over IFU. last_grant is still tracked but unused.

Test Plan:
- IFU only, ifu_addr=0x80000000, mem_req_ready=1, mem_resp_valid the cycle after REQ with rdata=0x00100073 → ifu_req_ready at cycle 0; mem_addr=0x80000000, mem_wen=0 at cycle 1; ifu_resp_valid=1, ifu_rdata=0x00100073, err=0 at cycle 2; lsu_resp_valid stays 0.
- Both valid in IDLE; LSU store addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF → fixed priority grants LSU first, mem_wen=1, mem_wdata=0xDEADBEEF; IFU is granted next in IDLE. With MEM_ARB_RR_EN and last_grant=LSU, IFU wins instead.
- mem_req_ready held 0 for 5 cycles → mem_req_valid and mem_addr stay stable all 5 cycles; ready outputs stay 0; transaction completes normally after mem_req_ready rises.
- TIMEOUT=4, no mem_resp_valid → owner resp_valid=1, err=1, rdata=0 on the 4th WAIT cycle; a mem_resp_valid arriving 2 cycles later in IDLE is dropped.
- rst pulsed asynchronously mid-WAIT → all outputs 0 immediately; no resp_valid pulse; the next IFU request is accepted normally after rst falls.
- mem_resp_valid asserted in the same cycle as timeout (TIMEOUT=3, response on the 3rd WAIT cycle) → err=0, rdata=mem_rdata.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between IFU (read-only) and LSU, one transaction in flight, with response timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority with LSU over IFU.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_resp_valid,
  output logic                  ifu_resp_err,
  output logic [DATA_W-1:0]     ifu_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_resp_valid,
  output logic                  lsu_resp_err,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic        TMO_EN = (TIMEOUT != 0);
  localparam logic [TMR_W-1:0] TMO_LAST = (TIMEOUT != 0) ? TMR_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  // owner_q / last_grant_q: 1 = LSU, 0 = IFU
  state_e              state_q;
  logic                owner_q;
  logic                last_grant_q;
  logic [TMR_W-1:0]    timer_q;
  logic [TMR_W-1:0]    timer_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;

  logic grant_lsu;
  logic grant_ifu;
  logic resp_hit;
  logic tmo_hit;

`ifdef MEM_ARB_RR_EN
  // On contention, favour whichever requester was not served last
  assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_grant_q);
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
  assign grant_lsu = lsu_req_valid;
`endif
  assign grant_ifu = ifu_req_valid & ~grant_lsu;

  assign resp_hit = (state_q == S_WAIT) & mem_resp_valid;
  // A real response in the final cycle takes precedence over the timeout
  assign tmo_hit  = (state_q == S_WAIT) & ~mem_resp_valid & TMO_EN & (timer_q == TMO_LAST);

  // Saturating increment so a disabled timeout never wraps
  always_comb begin
    timer_d = timer_q;
    if (timer_q != '1) timer_d = timer_q + TMR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      timer_q      <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_lsu) begin
            addr_q       <= lsu_addr;
            wen_q        <= lsu_wen;
            wdata_q      <= lsu_wdata;
            wmask_q      <= lsu_wmask;
            owner_q      <= 1'b1;
            last_grant_q <= 1'b1;
            state_q      <= S_REQ;
          end else if (grant_ifu) begin
            addr_q       <= ifu_addr;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            state_q      <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            timer_q <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (resp_hit || tmo_hit) state_q <= S_IDLE;
          else                     timer_q <= timer_d;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ifu_req_ready  = ~rst & (state_q == S_IDLE) & grant_ifu;
  assign lsu_req_ready  = ~rst & (state_q == S_IDLE) & grant_lsu;

  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;

  // Responses are steered to the owner only; the other side stays quiet
  assign ifu_resp_valid = (resp_hit | tmo_hit) & ~owner_q;
  assign ifu_resp_err   = tmo_hit & ~owner_q;
  assign ifu_rdata      = (resp_hit & ~owner_q) ? mem_rdata : '0;
  assign lsu_resp_valid = (resp_hit | tmo_hit) & owner_q;
  assign lsu_resp_err   = tmo_hit & owner_q;
  assign lsu_rdata      = (resp_hit & owner_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a response scoreboard; a TIMEOUT=3 twin covers the short-timeout cases.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  logic        u3_ifu_req_ready, u3_ifu_resp_valid, u3_ifu_resp_err;
  logic [31:0] u3_ifu_rdata;
  logic        u3_lsu_req_ready, u3_lsu_resp_valid, u3_lsu_resp_err;
  logic [31:0] u3_lsu_rdata;
  logic        u3_mem_req_valid, u3_mem_wen;
  logic [31:0] u3_mem_addr, u3_mem_wdata;
  logic [3:0]  u3_mem_wmask;

  typedef struct {
    logic        is_ifu;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic g_ifu;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_err(ifu_resp_err), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_err(lsu_resp_err), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(3)) u3 (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(u3_ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(u3_ifu_resp_valid), .ifu_resp_err(u3_ifu_resp_err), .ifu_rdata(u3_ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(u3_lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(u3_lsu_resp_valid), .lsu_resp_err(u3_lsu_resp_err), .lsu_rdata(u3_lsu_rdata),
    .mem_req_valid(u3_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(u3_mem_addr),
    .mem_wen(u3_mem_wen), .mem_wdata(u3_mem_wdata), .mem_wmask(u3_mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic dut_any_out();
    return |{ifu_req_ready, ifu_resp_valid, ifu_resp_err, ifu_rdata, lsu_req_ready,
             lsu_resp_valid, lsu_resp_err, lsu_rdata, mem_req_valid, mem_addr,
             mem_wen, mem_wdata, mem_wmask};
  endfunction

  function automatic logic u3_any_out();
    return |{u3_ifu_req_ready, u3_ifu_resp_valid, u3_ifu_resp_err, u3_ifu_rdata,
             u3_lsu_req_ready, u3_lsu_resp_valid, u3_lsu_resp_err, u3_lsu_rdata,
             u3_mem_req_valid, u3_mem_addr, u3_mem_wen, u3_mem_wdata, u3_mem_wmask};
  endfunction

  // Checks ready outputs in the current IDLE cycle and that no response is pulsing
  task automatic grant_chk(input logic exp_ifu, input logic exp_lsu);
    @(negedge clk);
    chk("ready_ifu", 64'(ifu_req_ready), 64'(exp_ifu));
    chk("ready_lsu", 64'(lsu_req_ready), 64'(exp_lsu));
    chk("resp_idle", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
  endtask

  // Called in the REQ cycle: optional stall, handshake, one-cycle response
  task automatic serve(input logic [31:0] rd, input int stall, input logic [31:0] a,
                       input logic w, input logic [31:0] wd, input logic [3:0] wm);
    mem_req_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(mem_req_valid), 64'd1);
      chk("stall_addr", 64'(mem_addr), 64'(a));
      chk("stall_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
      step();
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("req_valid", 64'(mem_req_valid), 64'd1);
    chk("req_addr", 64'(mem_addr), 64'(a));
    chk("req_wen", 64'(mem_wen), 64'(w));
    chk("req_wdata", 64'(mem_wdata), 64'(wd));
    chk("req_wmask", 64'(mem_wmask), 64'(wm));
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rd;
    @(negedge clk);
    chk("resp_pulse", 64'(ifu_resp_valid | lsu_resp_valid), 64'd1);
    chk("wait_req_valid", 64'(mem_req_valid), 64'd0);
    step();
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  // Scoreboard: every response pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && (ifu_resp_valid || lsu_resp_valid)) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed ifu=%0b lsu=%0b expected no response",
               ifu_resp_valid, lsu_resp_valid);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("resp_ifu_valid", 64'(ifu_resp_valid), 64'(mon_e.is_ifu));
        chk("resp_lsu_valid", 64'(lsu_resp_valid), 64'(!mon_e.is_ifu));
        chk("resp_err", 64'(mon_e.is_ifu ? ifu_resp_err : lsu_resp_err), 64'(mon_e.err));
        chk("resp_rdata", 64'(mon_e.is_ifu ? ifu_rdata : lsu_rdata), 64'(mon_e.rdata));
        chk("resp_other_zero",
            64'(mon_e.is_ifu ? {lsu_resp_err, lsu_rdata} : {ifu_resp_err, ifu_rdata}), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef MEM_ARB_RR_EN
    g_ifu = 1'b1;
`else
    g_ifu = 1'b0;
`endif
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    #2;
    chk("rst_dut_outputs_zero", 64'(dut_any_out()), 64'd0);
    chk("rst_u3_outputs_zero", 64'(u3_any_out()), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rst = 1'b0;
    step();

    // IFU-only fetch
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    grant_chk(1'b1, 1'b0);
    sb.push_back('{is_ifu: 1'b1, err: 1'b0, rdata: 32'h0010_0073});
    step();
    ifu_req_valid = 1'b0;
    serve(32'h0010_0073, 0, 32'h8000_0000, 1'b0, 32'h0, 4'h0);

    // Contention: LSU store wins first (last grant was IFU in both modes)
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    grant_chk(1'b0, 1'b1);
    sb.push_back('{is_ifu: 1'b0, err: 1'b0, rdata: 32'h0});
    step();
    lsu_req_valid = 1'b0;
    serve(32'h0, 0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);

    // Contention again after an LSU grant: round-robin picks IFU, fixed priority picks LSU
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
    lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    grant_chk(g_ifu, !g_ifu);
    sb.push_back('{is_ifu: g_ifu, err: 1'b0, rdata: g_ifu ? 32'hAAAA_0001 : 32'hBBBB_0002});
    step();
    if (g_ifu) ifu_req_valid = 1'b0;
    else       lsu_req_valid = 1'b0;
    serve(g_ifu ? 32'hAAAA_0001 : 32'hBBBB_0002, 0,
          g_ifu ? 32'h8000_0004 : 32'h8000_2000, 1'b0, 32'h0, 4'h0);
    grant_chk(!g_ifu, g_ifu);
    sb.push_back('{is_ifu: !g_ifu, err: 1'b0, rdata: g_ifu ? 32'hBBBB_0002 : 32'hAAAA_0001});
    step();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    serve(g_ifu ? 32'hBBBB_0002 : 32'hAAAA_0001, 0,
          g_ifu ? 32'h8000_2000 : 32'h8000_0004, 1'b0, 32'h0, 4'h0);

    // Memory stalls the request for 5 cycles
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000;
    grant_chk(1'b0, 1'b1);
    sb.push_back('{is_ifu: 1'b0, err: 1'b0, rdata: 32'h1234_5678});
    step();
    lsu_req_valid = 1'b0;
    serve(32'h1234_5678, 5, 32'h8000_3000, 1'b0, 32'h0, 4'h0);

    // Timeout: no response; TIMEOUT=4 fires on WAIT cycle 4, TIMEOUT=3 twin on cycle 3
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_4000;
    grant_chk(1'b1, 1'b0);
    sb.push_back('{is_ifu: 1'b1, err: 1'b1, rdata: 32'h0});
    step();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      @(negedge clk);
      chk("tmo4_pulse", 64'(ifu_resp_valid), 64'(w == 4));
      chk("tmo3_pulse", 64'(u3_ifu_resp_valid), 64'(w == 3));
      chk("tmo3_err", 64'(u3_ifu_resp_err), 64'(w == 3));
      step();
    end
    step();
    mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("stray_resp_dropped", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
    chk("stray_resp_dropped_u3", 64'({u3_ifu_resp_valid, u3_lsu_resp_valid}), 64'd0);
    step();
    mem_resp_valid = 1'b0; mem_rdata = '0;

    // Response in the final timeout cycle of the TIMEOUT=3 twin beats the error
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_5000;
    grant_chk(1'b1, 1'b0);
    sb.push_back('{is_ifu: 1'b1, err: 1'b0, rdata: 32'hCAFE_F00D});
    step();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step();
    step();
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("race_u3_valid", 64'(u3_ifu_resp_valid), 64'd1);
    chk("race_u3_err", 64'(u3_ifu_resp_err), 64'd0);
    chk("race_u3_rdata", 64'(u3_ifu_rdata), 64'hCAFE_F00D);
    step();
    mem_resp_valid = 1'b0; mem_rdata = '0;

    // Asynchronous reset mid-WAIT abandons the fetch silently
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_6000;
    grant_chk(1'b1, 1'b0);
    step();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step();
    #2;
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_7000;
    mem_resp_valid = 1'b1; mem_rdata = 32'h1111_1111;
    #1;
    chk("midrst_outputs_zero", 64'(dut_any_out()), 64'd0);
    chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
    @(posedge clk);
    #3;
    mem_resp_valid = 1'b0; mem_rdata = '0;
    rst = 1'b0;
    grant_chk(1'b1, 1'b0);
    sb.push_back('{is_ifu: 1'b1, err: 1'b0, rdata: 32'h0000_0013});
    step();
    ifu_req_valid = 1'b0;
    serve(32'h0000_0013, 0, 32'h8000_7000, 1'b0, 32'h0, 4'h0);

    step();
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
